data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Responder end of the core data bus for the two-copy contract harness: accepts LSU requests (req/gnt/rvalid), holds a small word-addressed data memory, and returns responses after a fixed, parameterised grant delay and response latency. It also exports the memory image and a circular log of granted addresses to the contract checker. Each core copy gets one instance, clocked by that copy's gated clock.

## Interface
Parameters:
- NUM_WORDS, 8, memory size in 32-bit words; power of two.
- LOG_DEPTH, 32, address-log entries; power of two.
- GNT_DELAY, 0, cycles `data_req_i` must be held before `data_gnt_o` (0 = same-cycle grant).
- RESP_LATENCY, 1, cycles from grant edge to `data_rvalid_o`; ≥1.
- MAX_OUTSTANDING, 2, granted but unanswered requests allowed; ≥1, ≤RESP_LATENCY+1.

Ports:
- clk_i  in  1  clock (one clock domain).
- rst_ni  in  1  asynchronous, active-low reset.
- data_req_i  in  1  request valid; held stable with address/data until granted.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables (writes only).
- data_addr_i  in  32  byte address; bits [1:0] ignored.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  request accepted this cycle.
- data_rvalid_o  out  1  response valid, one cycle per granted request.
- data_rdata_o  out  32  read data; 0 for writes.
- data_err_o  out  1  response error, qualified by rvalid.
- mem_data_o  out  NUM_WORDS×32  current memory image.
- addr_log_o  out  LOG_DEPTH×32  granted addresses, circular.
- log_count_o  out  $clog2(LOG_DEPTH)+1  number of valid log entries, saturating.

## Operation
- Grant FSM: IDLE (no req) → STALL (req high, wait counter < GNT_DELAY) → GRANT (gnt high one cycle) → IDLE, or STALL if req is still high (next request).
- GNT_DELAY=0: GRANT is combinational in the first req cycle; back-to-back grants are allowed every cycle.
- Wait counter increments each cycle req is high without a grant; clears on grant or req low.
- Grant is withheld while outstanding == MAX_OUTSTANDING. A response leaving in the same cycle frees its slot for a grant in that cycle.
- Word index = data_addr_i[31:2]; in range iff index < NUM_WORDS.
- Write: on the grant edge, bytes with be=1 update; other bytes are unchanged. The response carries rdata=0.
- Read: the word is sampled at the grant edge. A read granted the cycle after a write returns the written data.
- Responses are in order and issued through a RESP_LATENCY-deep shift pipeline. rvalid is high exactly one cycle, at edge g+RESP_LATENCY, with rdata/err. rdata/err are 0 when rvalid is low.
- Every grant writes data_addr_i (full 32 bits) to addr_log[wr_ptr]. wr_ptr wraps modulo LOG_DEPTH; the oldest entry is overwritten; log_count saturates at LOG_DEPTH.
- Requester dropping req before grant: the counter clears; no side effects.

## Timing
- Reset (asynchronous, immediate): gnt=0, rvalid=0, rdata=0, err=0, memory all 0, log all 0, log_count=0, wr_ptr=0, pipeline empty, FSM IDLE.
- Reset mid-operation: in-flight responses are discarded; no rvalid after reset release.
- Grant latency: GNT_DELAY cycles after req rise, plus any outstanding-limit stall.
- Response latency: exactly RESP_LATENCY cycles after the grant edge.
- Throughput: one request per cycle when GNT_DELAY=0 and MAX_OUTSTANDING ≥ RESP_LATENCY.
- Memory and log outputs are registered; they reflect a grant one edge after it.

## Configuration
- DATA_RESP_ERR_EN defined: an out-of-range access does not write, returns rdata=0 and err=1 with its rvalid, and is still logged.
- DATA_RESP_ERR_EN undefined: the index wraps modulo NUM_WORDS, and data_err_o is tied 0.

## Structure
- Package data_resp_pkg:
  - resp_entry_t struct {valid, rdata[31:0], err}.
  - grant FSM state enum (IDLE, STALL, GRANT).
  - word/byte width constants.
- Sub-module data_resp_pipe: RESP_LATENCY-stage shift register of resp_entry_t with an outstanding counter. Top level holds the FSM, memory and log.

## Test plan
- Write 0xDEADBEEF to 0x4 with be=0xF, then read 0x4, defaults → gnt same cycle each; read rvalid 1 cycle after grant with rdata=0xDEADBEEF, err=0.
- Write 0x000000AA to 0x8 with be=0x1 over a word holding 0x11223344 → mem_data_o[2]=0x112233AA.
- GNT_DELAY=3, RESP_LATENCY=2, req held from cycle 0 → gnt at cycle 3, rvalid at cycle 5; release req at cycle 2 → no grant and no log entry.
- MAX_OUTSTANDING=1, RESP_LATENCY=3, continuous reads → grants at cycles 0, 3 and 6 (each in the cycle its predecessor responds).
- Read 0x40 with NUM_WORDS=8 → with DATA_RESP_ERR_EN: err=1, rdata=0; without: returns word 0.
- 33 grants → log_count=32, addr_log[0] holds the 33rd address. Assert rst_ni with one response in flight → rvalid never asserts.

Source files
------------

// File: rtl/data_resp_pkg.sv
// data_resp_pkg: shared types and widths for the data bus responder.
// Holds the response pipeline entry and the grant FSM state encoding.
package data_resp_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = WORD_W / BYTE_W;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] rdata;
    logic              err;
  } resp_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    GRANT
  } gnt_state_t;

endpackage

// File: rtl/data_resp_pipe.sv
// data_resp_pipe: fixed-latency in-order response shift register.
// Tracks outstanding responses and tells the grant logic when a slot is free.
module data_resp_pipe
  import data_resp_pkg::*;
#(
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  resp_entry_t entry_i,
  output resp_entry_t resp_o,
  output logic        ready_o
);

  localparam int unsigned OW = $clog2(RESP_LATENCY + 2);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

  resp_entry_t [RESP_LATENCY-1:0] stage_q;
  logic [OW-1:0] out_q;
  logic          pop;

  assign pop     = stage_q[RESP_LATENCY-1].valid;
  assign resp_o  = stage_q[RESP_LATENCY-1];
  assign ready_o = (out_q < MAX_O) || pop;

  // Shift responses one stage per cycle; empty slots carry zeros.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= push_i ? entry_i : '0;
      for (int i = 1; i < int'(RESP_LATENCY); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Count granted but unanswered requests.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else begin
      unique case ({push_i, pop})
        2'b10:   out_q <= out_q + 1'b1;
        2'b01:   out_q <= out_q - 1'b1;
        default: out_q <= out_q;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: LSU data bus responder with memory and address log.
// Optional DATA_RESP_ERR_EN flags out-of-range accesses instead of wrapping.
module data_bus_responder
  import data_resp_pkg::*;
#(
  parameter int unsigned NUM_WORDS       = 8,
  parameter int unsigned LOG_DEPTH       = 32,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                data_req_i,
  input  logic                                data_we_i,
  input  logic [NUM_BYTES-1:0]                data_be_i,
  input  logic [WORD_W-1:0]                   data_addr_i,
  input  logic [WORD_W-1:0]                   data_wdata_i,
  output logic                                data_gnt_o,
  output logic                                data_rvalid_o,
  output logic [WORD_W-1:0]                   data_rdata_o,
  output logic                                data_err_o,
  output logic [NUM_WORDS-1:0][WORD_W-1:0]    mem_data_o,
  output logic [LOG_DEPTH-1:0][WORD_W-1:0]    addr_log_o,
  output logic [$clog2(LOG_DEPTH):0]          log_count_o
);

  localparam int unsigned IW  = $clog2(NUM_WORDS);
  localparam int unsigned LW  = $clog2(LOG_DEPTH);
  localparam int unsigned CW  = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam logic [CW-1:0] DLY  = CW'(GNT_DELAY);
  localparam logic [LW:0]   LMAX = (LW+1)'(LOG_DEPTH);

  gnt_state_t  state_q;
  logic [CW-1:0] wait_cnt_q;
  logic        wait_ok;
  logic        pipe_ready;
  logic        gnt;
  logic        in_range;
  logic [IW-1:0] widx;
  resp_entry_t entry;
  resp_entry_t resp;

  logic [NUM_WORDS-1:0][WORD_W-1:0] mem_q;
  logic [LOG_DEPTH-1:0][WORD_W-1:0] log_q;
  logic [LW-1:0] wr_ptr_q;
  logic [LW:0]   log_cnt_q;

  assign widx = data_addr_i[IW+1:2];

`ifdef DATA_RESP_ERR_EN
  assign in_range = (data_addr_i[WORD_W-1:IW+2] == '0);
`else
  assign in_range = 1'b1;
`endif

  assign wait_ok = (GNT_DELAY == 0) || (wait_cnt_q == DLY);
  assign gnt     = data_req_i && wait_ok && pipe_ready;

  // Grant FSM: count held request cycles up to the grant delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else if (!data_req_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else if (gnt) begin
      state_q    <= GRANT;
      wait_cnt_q <= '0;
    end else begin
      state_q <= STALL;
      unique case (state_q)
        STALL: begin
          if (wait_cnt_q != DLY) wait_cnt_q <= wait_cnt_q + 1'b1;
        end
        default: begin
          wait_cnt_q <= (GNT_DELAY != 0) ? CW'(1) : '0;
        end
      endcase
    end
  end

  // Build the response for the request granted this cycle.
  always_comb begin
    entry       = '0;
    entry.valid = gnt;
    entry.err   = gnt && !in_range;
    if (gnt && !data_we_i && in_range) entry.rdata = mem_q[widx];
  end

  data_resp_pipe #(
    .RESP_LATENCY    (RESP_LATENCY),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt),
    .entry_i (entry),
    .resp_o  (resp),
    .ready_o (pipe_ready)
  );

  // Byte-masked memory write on the grant edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else if (gnt && data_we_i && in_range) begin
      for (int b = 0; b < int'(NUM_BYTES); b++) begin
        if (data_be_i[b]) begin
          mem_q[widx][b*BYTE_W +: BYTE_W] <= data_wdata_i[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Circular log of every granted address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      log_q     <= '0;
      wr_ptr_q  <= '0;
      log_cnt_q <= '0;
    end else if (gnt) begin
      log_q[wr_ptr_q] <= data_addr_i;
      wr_ptr_q        <= wr_ptr_q + 1'b1;
      if (log_cnt_q != LMAX) log_cnt_q <= log_cnt_q + 1'b1;
    end
  end

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = resp.valid;
  assign data_rdata_o  = resp.rdata;
  assign data_err_o    = resp.err;
  assign mem_data_o    = mem_q;
  assign addr_log_o    = log_q;
  assign log_count_o   = log_cnt_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: directed checks of the data bus responder.
// Three instances cover default, delayed-grant and single-outstanding setups.
module tb_data_bus_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

`ifdef DATA_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        req0, we0, gnt0, rv0, err0;
  logic [3:0]  be0;
  logic [31:0] addr0, wd0, rd0;
  logic [7:0][31:0]  m0;
  logic [31:0][31:0] l0;
  logic [5:0]  lc0;

  logic        req1, we1, gnt1, rv1, err1;
  logic [3:0]  be1;
  logic [31:0] addr1, wd1, rd1;
  logic [7:0][31:0]  m1;
  logic [31:0][31:0] l1;
  logic [5:0]  lc1;

  logic        req2, we2, gnt2, rv2, err2;
  logic [3:0]  be2;
  logic [31:0] addr2, wd2, rd2;
  logic [7:0][31:0]  m2;
  logic [31:0][31:0] l2;
  logic [5:0]  lc2;

  data_bus_responder u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req0), .data_we_i(we0), .data_be_i(be0),
    .data_addr_i(addr0), .data_wdata_i(wd0),
    .data_gnt_o(gnt0), .data_rvalid_o(rv0),
    .data_rdata_o(rd0), .data_err_o(err0),
    .mem_data_o(m0), .addr_log_o(l0), .log_count_o(lc0)
  );

  data_bus_responder #(.GNT_DELAY(3), .RESP_LATENCY(2)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req1), .data_we_i(we1), .data_be_i(be1),
    .data_addr_i(addr1), .data_wdata_i(wd1),
    .data_gnt_o(gnt1), .data_rvalid_o(rv1),
    .data_rdata_o(rd1), .data_err_o(err1),
    .mem_data_o(m1), .addr_log_o(l1), .log_count_o(lc1)
  );

  data_bus_responder #(.RESP_LATENCY(3), .MAX_OUTSTANDING(1)) u2 (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_i(req2), .data_we_i(we2), .data_be_i(be2),
    .data_addr_i(addr2), .data_wdata_i(wd2),
    .data_gnt_o(gnt2), .data_rvalid_o(rv2),
    .data_rdata_o(rd2), .data_err_o(err2),
    .mem_data_o(m2), .addr_log_o(l2), .log_count_o(lc2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic u0_acc(input string tag, input logic we,
                        input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err);
    @(negedge clk);
    req0 = 1'b1; we0 = we; be0 = be; addr0 = addr; wd0 = wd;
    #1;
    check({tag, "_gnt"}, 32'(gnt0), 32'd1);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    check({tag, "_rv"}, 32'(rv0), 32'd1);
    check({tag, "_rd"}, rd0, exp_rd);
    check({tag, "_err"}, 32'(err0), 32'(exp_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int g, r, ab, ng, nrv;
  logic [7:0] gmask, rmask;

  initial begin
    req0 = 0; we0 = 0; be0 = 0; addr0 = 0; wd0 = 0;
    req1 = 0; we1 = 0; be1 = 0; addr1 = 0; wd1 = 0;
    req2 = 0; we2 = 0; be2 = 0; addr2 = 0; wd2 = 0;
    do_reset();
    #1;
    check("rst_gnt", 32'(gnt0), 32'd0);
    check("rst_rv", 32'(rv0), 32'd0);
    check("rst_rd", rd0, 32'd0);
    check("rst_lc", 32'(lc0), 32'd0);
    check("rst_mem", m0[3], 32'd0);

    u0_acc("wr4", 1, 4'hF, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0);
    check("mem1", m0[1], 32'hDEADBEEF);
    u0_acc("rd4", 0, 4'hF, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0);

    @(negedge clk);
    req0 = 1; we0 = 1; be0 = 4'hF; addr0 = 32'h8; wd0 = 32'h11223344;
    #1 check("b2b_wgnt", 32'(gnt0), 32'd1);
    @(negedge clk);
    we0 = 0;
    #1;
    check("b2b_rgnt", 32'(gnt0), 32'd1);
    check("b2b_wrv", 32'(rv0), 32'd1);
    check("b2b_wrd", rd0, 32'd0);
    @(negedge clk);
    req0 = 0;
    #1;
    check("b2b_rrv", 32'(rv0), 32'd1);
    check("b2b_rrd", rd0, 32'h11223344);

    u0_acc("wrb0", 1, 4'h1, 32'h8, 32'h000000AA, 32'h0, 1'b0);
    check("mem2_be", m0[2], 32'h112233AA);
    u0_acc("wr0", 1, 4'hF, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);
    u0_acc("rd40", 0, 4'hF, 32'h40, 32'h0,
           ERR_EN ? 32'h0 : 32'hCAFEF00D, ERR_EN);
    u0_acc("wr44", 1, 4'hF, 32'h44, 32'h12345678, 32'h0, ERR_EN);
    check("mem1_oor", m0[1], ERR_EN ? 32'hDEADBEEF : 32'h12345678);
    check("lc_8", 32'(lc0), 32'd8);
    check("log7", l0[7], 32'h44);
    check("log0", l0[0], 32'h4);

    g = -1; r = -1;
    @(negedge clk);
    req1 = 1; addr1 = 32'h10;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (gnt1 && g < 0) g = k;
      if (rv1 && r < 0) r = k;
      @(negedge clk);
      if (g >= 0) req1 = 0;
    end
    check("dly_gnt_cyc", 32'(g), 32'd3);
    check("dly_rv_cyc", 32'(r), 32'd5);
    check("dly_lc", 32'(lc1), 32'd1);

    ab = 0;
    @(negedge clk);
    req1 = 1; addr1 = 32'h20;
    for (int k = 0; k < 2; k++) begin
      #1 if (gnt1) ab++;
      @(negedge clk);
    end
    req1 = 0;
    #1 if (gnt1) ab++;
    @(negedge clk);
    #1;
    check("abort_gnt", 32'(ab), 32'd0);
    check("abort_lc", 32'(lc1), 32'd1);

    g = -1;
    @(negedge clk);
    req1 = 1; addr1 = 32'h14;
    for (int k = 0; k < 6; k++) begin
      #1 if (gnt1 && g < 0) g = k;
      @(negedge clk);
      if (g >= 0) req1 = 0;
    end
    check("regnt_cyc", 32'(g), 32'd3);
    check("regnt_lc", 32'(lc1), 32'd2);
    check("regnt_log", l1[1], 32'h14);

    gmask = '0; rmask = '0;
    @(negedge clk);
    req2 = 1; addr2 = 32'h0;
    for (int k = 0; k < 8; k++) begin
      #1;
      gmask[k] = gnt2;
      rmask[k] = rv2;
      @(negedge clk);
    end
    req2 = 0;
    check("out1_gnt", 32'(gmask), 32'h49);
    check("out1_rv", 32'(rmask), 32'h48);
    repeat (4) @(negedge clk);

    do_reset();
    ng = 0;
    @(negedge clk);
    req0 = 1; we0 = 0;
    for (int i = 0; i < 33; i++) begin
      addr0 = 32'(i * 4);
      #1 if (gnt0) ng++;
      @(negedge clk);
    end
    req0 = 0;
    #1;
    check("log_gnts", 32'(ng), 32'd33);
    check("log_sat", 32'(lc0), 32'd32);
    check("log_wrap0", l0[0], 32'h80);
    check("log_1", l0[1], 32'h4);
    check("log_31", l0[31], 32'h7C);

    @(negedge clk);
    req2 = 1; addr2 = 32'h8;
    #1 check("inflt_gnt", 32'(gnt2), 32'd1);
    @(negedge clk);
    req2 = 0;
    rst_n = 0;
    #3;
    check("inflt_rst_rv", 32'(rv2), 32'd0);
    check("inflt_rst_lc", 32'(lc2), 32'd0);
    @(negedge clk);
    rst_n = 1;
    nrv = 0;
    for (int k = 0; k < 6; k++) begin
      #1 if (rv2) nrv++;
      @(negedge clk);
    end
    check("inflt_norv", 32'(nrv), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
